// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: op-code constants and the status flag bundle.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu16_if.sv
// Operand/result bundle between the datapath controller (master) and the ALU (slave).
interface alu16_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [2:0]       code;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output en, code, operand1, operand2,
    input  result, valid, carry, zero, negative, overflow
  );

  modport slave (
    input  en, code, operand1, operand2,
    output result, valid, carry, zero, negative, overflow
  );
endinterface

// File: rtl/alu16_comb.sv
// Combinational ALU datapath: next result and flags from op code and operands.
module alu16_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [SHW-1:0]   shamt;
  logic             sign_a;
  logic             sign_b;
  logic             lt_signed;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign shamt  = b[SHW-1:0];
  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1];

  // One extra bit on the outgoing side of each shift catches the last bit shifted out.
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;

  // Same signs: the unsigned borrow decides; different signs: A is smaller iff negative.
  assign lt_signed = (sign_a != sign_b) ? sign_a : diff[WIDTH];

  always_comb begin
    result = '0;
    flags  = '0;
    case (code)
      ALU_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      ALU_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result      = shl_ext[WIDTH-1:0];
        flags.carry = shl_ext[WIDTH];
      end
      ALU_SHR: begin
        result      = shr_ext[WIDTH:1];
        flags.carry = shr_ext[0];
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu16.sv
// Registered ALU: captures the combinational datapath output when enabled, one-cycle latency.
module alu16
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  alu16_if.slave  bus
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;
  logic             valid_q;

  alu16_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .code   (bus.code),
    .a      (bus.operand1),
    .b      (bus.operand2),
    .result (result_d),
    .flags  (flags_d)
  );

  // Result and flags hold while en is low; valid only marks the cycle after a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else if (bus.en) begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.result   = result_q;
  assign bus.valid    = valid_q;
  assign bus.carry    = flags_q.carry;
  assign bus.zero     = flags_q.zero;
  assign bus.negative = flags_q.negative;
  assign bus.overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: directed corner cases then randomized traffic against an arithmetic model.
module tb_alu16;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_on   = 0;

  exp_t exp_q[$];
  exp_t held;
  logic mdl_valid;

  alu16_if #(.WIDTH(16)) bus ();

  alu16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint r;
    int     n = b[3:0];
    e.c = 1'b0;
    e.v = 1'b0;
    case (c)
      3'd0: begin
        r   = ua + ub;
        e.c = (r > 65535);
        e.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        r   = ua - ub;
        e.c = (ua < ub);
        e.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r   = ua << n;
        e.c = (n != 0) && (((ua >> (16 - n)) & 1) == 1);
      end
      3'd6: begin
        r   = ua >> n;
        e.c = (n != 0) && (((ua >> (n - 1)) & 1) == 1);
      end
      default: r = (sa < sb) ? 1 : 0;
    endcase
    e.res = r[15:0];
    e.z   = (e.res == 16'h0000);
    e.n   = e.res[15];
    return e;
  endfunction

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {res,c,z,n,v,valid}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the model advances at the same edge the DUT samples.
  task automatic cyc(input logic r, input logic e, input logic [2:0] c,
                     input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    rst          = r;
    bus.en       = e;
    bus.code     = c;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk);
    if (r) begin
      held      = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      mdl_valid = 1'b0;
    end else if (e) begin
      x         = ref_op(c, a, b);
      held      = x;
      mdl_valid = 1'b1;
      exp_q.push_back(x);
    end else begin
      mdl_valid = 1'b0;
    end
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [20:0] act;
    if (mon_on) begin
      act = {bus.result, bus.carry, bus.zero, bus.negative, bus.overflow, bus.valid};
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_issue", act, {held.res, held.c, held.z, held.n, held.v, 1'b0});
        end else begin
          e = exp_q.pop_front();
          chk("result", act, {e.res, e.c, e.z, e.n, e.v, 1'b1});
        end
      end else begin
        chk("hold", act, {held.res, held.c, held.z, held.n, held.v, mdl_valid});
      end
    end
  end

  initial begin
    held      = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    mdl_valid = 1'b0;

    cyc(1'b1, 1'b1, ALU_ADD, 16'h1234, 16'h5678);
    mon_on = 1;
    cyc(1'b1, 1'b1, ALU_ADD, 16'h1234, 16'h5678);

    cyc(1'b0, 1'b1, ALU_ADD, 16'h0005, 16'h0003);
    cyc(1'b0, 1'b1, ALU_ADD, 16'hFFFF, 16'h0001);
    cyc(1'b0, 1'b1, ALU_ADD, 16'h7FFF, 16'h0001);
    cyc(1'b0, 1'b1, ALU_SUB, 16'h0005, 16'h0003);
    cyc(1'b0, 1'b1, ALU_SUB, 16'h0000, 16'h0001);
    cyc(1'b0, 1'b1, ALU_SUB, 16'h8000, 16'h0001);
    cyc(1'b0, 1'b1, ALU_AND, 16'h000F, 16'h003C);
    cyc(1'b0, 1'b1, ALU_OR,  16'h000F, 16'h003C);
    cyc(1'b0, 1'b1, ALU_XOR, 16'h000F, 16'h003C);
    cyc(1'b0, 1'b1, ALU_SHL, 16'h8001, 16'h0001);
    cyc(1'b0, 1'b1, ALU_SHL, 16'h8001, 16'h0000);
    cyc(1'b0, 1'b1, ALU_SHL, 16'h0001, 16'h000F);
    cyc(1'b0, 1'b1, ALU_SHR, 16'h0003, 16'h0001);
    cyc(1'b0, 1'b1, ALU_SHR, 16'h8000, 16'h000F);
    cyc(1'b0, 1'b1, ALU_SLT, 16'hFFFF, 16'h0001);
    cyc(1'b0, 1'b1, ALU_SLT, 16'h0001, 16'hFFFF);

    cyc(1'b0, 1'b1, ALU_ADD, 16'h7FFF, 16'h0001);
    cyc(1'b0, 1'b0, ALU_SUB, 16'h0000, 16'h0001);
    cyc(1'b0, 1'b0, ALU_XOR, 16'hAAAA, 16'h5555);
    cyc(1'b1, 1'b1, ALU_ADD, 16'hFFFF, 16'hFFFF);
    cyc(1'b0, 1'b0, ALU_ADD, 16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), pick(), pick());
    end

    cyc(1'b0, 1'b0, ALU_ADD, 16'h0000, 16'h0000);
    @(negedge clk);
    #1;
    mon_on = 0;
    chk("queue_drained", {5'd0, 16'(exp_q.size())}, 21'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
